pipe_rx_buffer: RTL and testbench
=================================

PIPE_RX_BUFFER -- requirements
Module: pipe_rx_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 9, data word width; this matches the 9-bit result of the upstream add pipeline.
REQ-002 SHALL have parameter DEPTH, default 4, number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter AF_LEVEL, default 2, occupancy at which almost_full asserts; legal range is 1 to DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port flush, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream word present this cycle; there is no backpressure on this input.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-008 SHALL have port out_valid, output, 1 bit: head word available.
REQ-009 SHALL have port out_data, output, WIDTH bits: head word, first-word fall-through.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the head word.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port almost_full, output, 1 bit: asserted when count >= AF_LEVEL.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag indicating a word was dropped.
REQ-014 SHALL have port word_count, output, 16 bits: count of accepted words (see Configuration).

Function
REQ-015 Push condition SHALL be in_valid; pop condition SHALL be out_valid && out_ready.
REQ-016 A word pushed at rising edge N SHALL appear on out_data with out_valid=1 immediately after edge N, when the FIFO was empty; latency is 1 edge.
REQ-017 Words SHALL leave in arrival order; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 out_valid SHALL equal (count != 0); all outputs SHALL be driven only from registers.
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged, including when count=DEPTH, in which case both the push and the pop are accepted.
REQ-020 A push with count=DEPTH and no pop SHALL drop in_data, leave the FIFO contents unchanged, and set overflow=1 at that edge.
REQ-021 out_ready with count=0 SHALL be ignored; the FIFO SHALL NOT underflow.
REQ-022 overflow SHALL remain 1 until flush; it is not cleared by draining.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL never exceed DEPTH.

Reset
REQ-025 flush=1 SHALL immediately and asynchronously force count=0, out_valid=0, out_data=0, almost_full=0, overflow=0, word_count=0, and both pointers to 0.
REQ-026 A flush asserted mid-stream SHALL discard all stored words; the first in_valid sampled after flush deasserts SHALL be stored as the new head.

Configuration
REQ-027 With macro PIPE_RX_WORD_COUNT_EN defined, word_count SHALL increment by 1 on each accepted push and wrap from 16'hFFFF to 0.
REQ-028 Without PIPE_RX_WORD_COUNT_EN, word_count SHALL be constant 0 and no counter register SHALL be built.
REQ-029 Dropped words (REQ-020) SHALL NOT increment word_count.

Verification
REQ-030 Bench SHALL cover basic flow: flush, then push 9'h0A with out_ready=1 -> out_valid=1 with out_data=9'h0A after 1 edge; popped on the next edge; count returns to 0.
REQ-031 Bench SHALL cover fill and overflow: out_ready=0, push 9'h001..9'h005 on consecutive cycles -> count=4, almost_full=1 from count=2, overflow=1 after the 5th push; the FIFO then drains 001,002,003,004.
REQ-032 Bench SHALL cover simultaneous push and pop when full: count=4, in_valid=1 with 9'h1FF, out_ready=1 -> count stays 4, the head advances, and 9'h1FF is the last word drained.
REQ-033 Bench SHALL cover flush mid-stream: 3 words stored, flush pulsed between edges -> all outputs read 0 immediately; the next push 9'h055 becomes the head.
REQ-034 Bench SHALL cover the word counter: with PIPE_RX_WORD_COUNT_EN, 65537 accepted pushes -> word_count=1; without the macro, word_count=0 throughout.
REQ-035 Bench SHALL cover the empty pop: out_ready=1 and in_valid=0 for 3 cycles after flush -> count=0 and out_valid=0, with no pointer movement.

Source files
------------

// File: rtl/pipe_rx_buffer.sv
// pipe_rx_buffer: first-word fall-through receive FIFO behind the 9-bit add
// pipeline. The input has no backpressure, so words arriving while the FIFO is
// full are dropped and latched in a sticky overflow flag.
//
// Optional feature: define PIPE_RX_WORD_COUNT_EN to build a 16-bit wrapping
// counter of accepted pushes on word_count. Without it word_count is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   flush        in   asynchronous active-high reset of all state
//   in_valid     in   upstream word present (push request)
//   in_data      in   upstream word
//   out_valid    out  head word available (count != 0)
//   out_data     out  head word, registered fall-through
//   out_ready    in   downstream accepts head word
//   count        out  current occupancy, 0..DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky: a word was dropped since the last flush
//   word_count   out  accepted-push counter (0 unless PIPE_RX_WORD_COUNT_EN)
module pipe_rx_buffer #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [15:0]              word_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             pop, push;

  // Next-state: a full FIFO still accepts a push when the head leaves that cycle.
  always_comb begin
    pop           = (count_q != '0) && out_ready;
    push          = in_valid && ((count_q != CW'(DEPTH)) || pop);
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    overflow_d    = overflow_q | (in_valid & ~push);
    out_valid_d   = (count_d != '0);
    almost_full_d = (count_d >= CW'(AF_LEVEL));

    // Registered head: next stored word, or the incoming word when it
    // becomes the only entry.
    out_data_d = out_data_q;
    if (count_d == '0) begin
      out_data_d = '0;
    end else if (pop) begin
      out_data_d = (count_q > CW'(1)) ? mem_q[rd_ptr_d] : in_data;
    end else if (count_q == '0) begin
      out_data_d = in_data;
    end
  end

  // Storage array, written at the tail; no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef PIPE_RX_WORD_COUNT_EN
  logic [15:0] word_count_q;

  // Accepted-push counter; dropped words do not count.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      word_count_q <= '0;
    end else if (push) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
`else
  assign word_count = '0;
`endif

  assign count       = count_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pipe_rx_buffer.sv
// tb_pipe_rx_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model of pipe_rx_buffer.
module tb_pipe_rx_buffer;

  localparam int unsigned WIDTH    = 9;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 2;

  logic                   clk = 1'b0;
  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   almost_full;
  logic                   overflow;
  logic [15:0]            word_count;

  pipe_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk         (clk),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] mdl_q[$];
  logic             mdl_ovf;
  logic [15:0]      mdl_wc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_wc  = '0;
  endtask

  // One clock edge of FIFO behaviour: head leaves first, then the arriving word
  // is kept if there is room, otherwise dropped.
  task automatic model_edge(input logic v, input logic [WIDTH-1:0] d, input logic r);
    if (r && mdl_q.size() > 0) void'(mdl_q.pop_front());
    if (v) begin
      if (mdl_q.size() < DEPTH) begin
        mdl_q.push_back(d);
`ifdef PIPE_RX_WORD_COUNT_EN
        mdl_wc = mdl_wc + 16'd1;
`endif
      end else begin
        mdl_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"},       32'(count),       32'(mdl_q.size()));
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) check_eq({tag, ".out_data"}, 32'(out_data), 32'(mdl_q[0]));
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(mdl_q.size() >= AF_LEVEL));
    check_eq({tag, ".overflow"},    32'(overflow),    32'(mdl_ovf));
    check_eq({tag, ".word_count"},  32'(word_count),  32'(mdl_wc));
  endtask

  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous flush pulse between edges; outputs must clear at once.
  task automatic do_flush(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    #1;
    model_clear();
    check_eq({tag, ".flush_count"}, 32'(count),       32'd0);
    check_eq({tag, ".flush_valid"}, 32'(out_valid),   32'd0);
    check_eq({tag, ".flush_data"},  32'(out_data),    32'd0);
    check_eq({tag, ".flush_af"},    32'(almost_full), 32'd0);
    check_eq({tag, ".flush_ovf"},   32'(overflow),    32'd0);
    check_eq({tag, ".flush_wc"},    32'(word_count),  32'd0);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    flush     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    #2;
    check_eq("reset.count",     32'(count),     32'd0);
    check_eq("reset.out_valid", 32'(out_valid), 32'd0);
    check_eq("reset.overflow",  32'(overflow),  32'd0);
    #10;
    flush = 1'b0;

    // Basic flow
    do_flush("basic");
    step("basic.push", 1'b1, 9'h00A, 1'b1);
    check_eq("basic.head", 32'(out_data), 32'h00A);
    step("basic.pop", 1'b0, 9'h000, 1'b1);
    check_eq("basic.empty", 32'(count), 32'd0);

    // Empty pop: no underflow, pointers stay put so the next push is the head
    do_flush("empty");
    for (int i = 0; i < 3; i++) step("empty.pop", 1'b0, 9'h000, 1'b1);
    step("empty.push", 1'b1, 9'h133, 1'b0);
    check_eq("empty.head", 32'(out_data), 32'h133);

    // Fill and overflow
    do_flush("fill");
    for (int i = 1; i <= 5; i++) step("fill.push", 1'b1, WIDTH'(i), 1'b0);
    check_eq("fill.count", 32'(count),    32'd4);
    check_eq("fill.ovf",   32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("fill.drain_data", 32'(out_data), 32'(i));
      step("fill.drain", 1'b0, 9'h000, 1'b1);
    end
    check_eq("fill.ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop while full
    do_flush("full_pp");
    for (int i = 1; i <= 4; i++) step("full_pp.fill", 1'b1, WIDTH'(i), 1'b0);
    step("full_pp.pp", 1'b1, 9'h1FF, 1'b1);
    check_eq("full_pp.count", 32'(count),    32'd4);
    check_eq("full_pp.head",  32'(out_data), 32'h002);
    check_eq("full_pp.ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_eq("full_pp.last", 32'(out_data), 32'h1FF);
      step("full_pp.drain", 1'b0, 9'h000, 1'b1);
    end

    // Flush mid-stream
    do_flush("mid");
    for (int i = 0; i < 3; i++) step("mid.push", 1'b1, WIDTH'(9'h0C0 + i), 1'b0);
    do_flush("mid");
    step("mid.new", 1'b1, 9'h055, 1'b0);
    check_eq("mid.head", 32'(out_data), 32'h055);

    // Randomized traffic with varying push/pop pressure
    do_flush("rand");
    for (int i = 0; i < 3000; i++) begin
      int unsigned pv, pr;
      if (i % 600 == 599) do_flush("rand");
      pv = 25 + 25 * ((i / 300) % 3);
      pr = 75 - 25 * ((i / 200) % 3);
      step("rand", ($urandom_range(0, 99) < pv), WIDTH'($urandom), ($urandom_range(0, 99) < pr));
    end

    // Word counter: 65537 accepted pushes wraps to 1 (or stays 0 if not built)
    do_flush("wc");
    for (int i = 0; i < 65537; i++) step("wc", 1'b1, WIDTH'($urandom), 1'b1);
`ifdef PIPE_RX_WORD_COUNT_EN
    check_eq("wc.wrap", 32'(word_count), 32'd1);
`else
    check_eq("wc.off",  32'(word_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
